// File: rtl/multireceive.sv
// Receiver for the 3-wire parallel symbol link: synchronizes and deglitches the
// strobe, collects DIGITS octal symbols MSD first and publishes the decimal value.
module multireceive #(
   parameter int unsigned DIGITS  = 6,
   parameter int unsigned SETTLE  = 4,
   parameter int unsigned TIMEOUT = 2400000
) (
   input  logic                  hwclk,
   input  logic                  rst_n,
   input  logic                  enabled,
   input  logic                  in0,
   input  logic                  in1,
   input  logic                  in2,
   input  logic                  controlIn,
   input  logic                  ack,
   output logic [19:0]           value,
   output logic [3*DIGITS-1:0]   symbols,
   output logic                  valid,
   output logic                  busy,
   output logic                  timeout_err,
   output logic                  overrun
);

   localparam int unsigned SW = 3 * DIGITS;
   localparam int unsigned CW = $clog2(DIGITS + 1);
   localparam int unsigned KW = $clog2(SETTLE + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_WAIT_LOW, ST_GAP} state_t;

   // Two-stage synchronizers for strobe and data, cleared only by rst_n
   logic [3:0] meta, sync;
   logic       ctl_s;
   logic [2:0] d_s;

   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         sync <= '0;
      end else begin
         meta <= {controlIn, in2, in1, in0};
         sync <= meta;
      end
   end

   assign ctl_s = sync[3];
   assign d_s   = sync[2:0];

   state_t        state, state_nxt;
   logic [CW-1:0] count, count_nxt;
   logic [KW-1:0] scnt, scnt_nxt;
   logic [TW-1:0] tmo_cnt, tmo_nxt;
   logic [19:0]   acc, acc_nxt, acc_cap;
   logic [SW-4:0] sh, sh_nxt;
   logic [SW-1:0] sh_cap;
   logic [19:0]   value_nxt;
   logic [SW-1:0] symbols_nxt;
   logic          valid_nxt, busy_nxt, terr_nxt, ovr_nxt, tmo_hit;

   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         count       <= '0;
         scnt        <= '0;
         tmo_cnt     <= '0;
         acc         <= '0;
         sh          <= '0;
         value       <= '0;
         symbols     <= '0;
         valid       <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         state       <= state_nxt;
         count       <= count_nxt;
         scnt        <= scnt_nxt;
         tmo_cnt     <= tmo_nxt;
         acc         <= acc_nxt;
         sh          <= sh_nxt;
         value       <= value_nxt;
         symbols     <= symbols_nxt;
         valid       <= valid_nxt;
         busy        <= busy_nxt;
         timeout_err <= terr_nxt;
         overrun     <= ovr_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      count_nxt   = count;
      scnt_nxt    = scnt;
      tmo_nxt     = tmo_cnt;
      acc_nxt     = acc;
      sh_nxt      = sh;
      value_nxt   = value;
      symbols_nxt = symbols;
      valid_nxt   = valid;
      terr_nxt    = timeout_err;
      ovr_nxt     = overrun;
      acc_cap     = 20'(acc * 20'd10) + 20'(d_s);
      sh_cap      = {sh, d_s};
      tmo_hit     = (tmo_cnt == TW'(TIMEOUT));

      if (valid && ack)
         valid_nxt = 1'b0;

      case (state)
         ST_IDLE: begin
            count_nxt = '0;
            acc_nxt   = '0;
            sh_nxt    = '0;
            scnt_nxt  = KW'(1);
            if (ctl_s)
               state_nxt = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (!ctl_s) begin
               state_nxt = (count == '0) ? ST_IDLE : ST_GAP;
               tmo_nxt   = '0;
            end else if (scnt == KW'(SETTLE - 1)) begin
               acc_nxt   = acc_cap;
               sh_nxt    = sh_cap[SW-4:0];
               count_nxt = count + CW'(1);
               tmo_nxt   = '0;
               state_nxt = ST_WAIT_LOW;
               // Final symbol: publish unless an unacknowledged frame is pending
               if (count == CW'(DIGITS - 1)) begin
                  if (!valid || ack) begin
                     value_nxt   = acc_cap;
                     symbols_nxt = sh_cap;
                     valid_nxt   = 1'b1;
                  end else begin
                     ovr_nxt = 1'b1;
                  end
               end
            end else begin
               scnt_nxt = scnt + KW'(1);
            end
         end
         ST_WAIT_LOW: begin
            if (tmo_hit) begin
               terr_nxt  = 1'b1;
               count_nxt = '0;
               acc_nxt   = '0;
               sh_nxt    = '0;
               tmo_nxt   = '0;
               state_nxt = ctl_s ? ST_WAIT_LOW : ST_IDLE;
            end else if (!ctl_s) begin
               // count==0 here means the frame was aborted while the strobe was high
               state_nxt = (count == CW'(DIGITS) || count == '0) ? ST_IDLE : ST_GAP;
               tmo_nxt   = '0;
            end else begin
               tmo_nxt = tmo_cnt + TW'(1);
            end
         end
         ST_GAP: begin
            if (tmo_hit) begin
               terr_nxt  = 1'b1;
               count_nxt = '0;
               acc_nxt   = '0;
               sh_nxt    = '0;
               tmo_nxt   = '0;
               state_nxt = ctl_s ? ST_WAIT_LOW : ST_IDLE;
            end else if (ctl_s) begin
               scnt_nxt  = KW'(1);
               state_nxt = ST_SETTLE;
            end else begin
               tmo_nxt = tmo_cnt + TW'(1);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      if (!enabled) begin
         state_nxt   = ST_IDLE;
         count_nxt   = '0;
         scnt_nxt    = '0;
         tmo_nxt     = '0;
         acc_nxt     = '0;
         sh_nxt      = '0;
         value_nxt   = '0;
         symbols_nxt = '0;
         valid_nxt   = 1'b0;
         terr_nxt    = 1'b0;
         ovr_nxt     = 1'b0;
      end

      busy_nxt = (state_nxt != ST_IDLE);
   end

endmodule

// File: tb/tb_multireceive.sv
// Directed bench for multireceive: frame table plus hand-written sequences for
// ack races, timeout, async reset and enable clear.
module tb_multireceive;

   localparam int unsigned DIGITS = 6;

   logic        hwclk, rst_n, enabled, in0, in1, in2, controlIn, ack;
   logic [19:0] value;
   logic [17:0] symbols;
   logic        valid, busy, timeout_err, overrun;

   int checks   = 0;
   int failures = 0;

   multireceive #(.DIGITS(6), .SETTLE(4), .TIMEOUT(1000)) dut (
      .hwclk(hwclk), .rst_n(rst_n), .enabled(enabled),
      .in0(in0), .in1(in1), .in2(in2), .controlIn(controlIn), .ack(ack),
      .value(value), .symbols(symbols), .valid(valid), .busy(busy),
      .timeout_err(timeout_err), .overrun(overrun)
   );

   initial hwclk = 1'b0;
   always #5 hwclk = ~hwclk;

   typedef struct {
      logic [17:0] frame;
      int          hi;
      int          lo;
      bit          glitch;
      bit          do_ack;
      logic [19:0] exp_value;
      logic [17:0] exp_sym;
      bit          exp_ovr;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive one symbol: strobe high for hi cycles, then low for lo cycles
   task automatic send_sym(input logic [2:0] s, input int hi, input int lo, output int lat);
      lat = -1;
      {in2, in1, in0} = s;
      controlIn = 1'b1;
      for (int c = 1; c <= hi; c++) begin
         @(negedge hwclk);
         if (valid && lat < 0) lat = c;
      end
      controlIn = 1'b0;
      repeat (lo) @(negedge hwclk);
   endtask

   task automatic send_frame(input logic [17:0] f, input int hi, input int lo,
                             input bit glitch, output int lat);
      logic [2:0] s;
      int         l;
      lat = -1;
      for (int i = 0; i < DIGITS; i++) begin
         s = f[17-3*i -: 3];
         send_sym(s, hi, lo, l);
         if (i == DIGITS - 1) lat = l;
         if (glitch && i < DIGITS - 1) begin
            controlIn = 1'b1;
            repeat (3) @(negedge hwclk);
            controlIn = 1'b0;
            repeat (lo) @(negedge hwclk);
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_value"}, 32'(value), 0);
      check({tag, "_symbols"}, 32'(symbols), 0);
      check({tag, "_valid"}, 32'(valid), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_timeout_err"}, 32'(timeout_err), 0);
      check({tag, "_overrun"}, 32'(overrun), 0);
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      @(negedge hwclk);
      ack = 1'b0;
   endtask

   initial begin
      int lat;
      logic [17:0] f;

      vecs[0] = '{18'o123456, 100, 100, 1'b0, 1'b1, 20'd123456, 18'o123456, 1'b0};
      vecs[1] = '{18'o707070, 10,  10,  1'b1, 1'b1, 20'd707070, 18'o707070, 1'b0};
      vecs[2] = '{18'o654321, 10,  10,  1'b0, 1'b1, 20'd654321, 18'o654321, 1'b0};
      vecs[3] = '{18'o000001, 10,  10,  1'b0, 1'b0, 20'd1,      18'o000001, 1'b0};
      vecs[4] = '{18'o000002, 10,  10,  1'b0, 1'b0, 20'd1,      18'o000001, 1'b1};

      rst_n = 1'b0; enabled = 1'b1; ack = 1'b0;
      controlIn = 1'b0; in0 = 1'b0; in1 = 1'b0; in2 = 1'b0;
      #1;
      check_all_zero("reset");
      repeat (3) @(negedge hwclk);
      rst_n = 1'b1;
      repeat (3) @(negedge hwclk);
      check_all_zero("post_reset");

      for (int v = 0; v < 5; v++) begin
         send_frame(vecs[v].frame, vecs[v].hi, vecs[v].lo, vecs[v].glitch, lat);
         if (v == 0) check("valid_latency_in_5_to_7", 32'((lat >= 5) && (lat <= 7)), 1);
         check($sformatf("vec%0d_value", v), 32'(value), 32'(vecs[v].exp_value));
         check($sformatf("vec%0d_symbols", v), 32'(symbols), 32'(vecs[v].exp_sym));
         check($sformatf("vec%0d_valid", v), 32'(valid), 1);
         check($sformatf("vec%0d_busy", v), 32'(busy), 0);
         check($sformatf("vec%0d_overrun", v), 32'(overrun), 32'(vecs[v].exp_ovr));
         if (vecs[v].do_ack) begin
            pulse_ack();
            check($sformatf("vec%0d_valid_after_ack", v), 32'(valid), 0);
         end
      end

      // Overrun recovery: ack clears valid, next frame publishes, overrun sticky
      pulse_ack();
      check("ovr_ack_valid", 32'(valid), 0);
      send_frame(18'o000003, 10, 10, 1'b0, lat);
      check("frame3_value", 32'(value), 3);
      check("frame3_valid", 32'(valid), 1);
      check("frame3_overrun_sticky", 32'(overrun), 1);

      // enabled low for one edge clears everything
      enabled = 1'b0;
      @(negedge hwclk);
      enabled = 1'b1;
      check_all_zero("enable_clear");

      // ack coincident with last capture of the second frame
      send_frame(18'o000011, 10, 10, 1'b0, lat);
      check("race_first_value", 32'(value), 11);
      check("race_first_valid", 32'(valid), 1);
      f = 18'o000022;
      for (int i = 0; i < DIGITS - 1; i++) send_sym(f[17-3*i -: 3], 10, 10, lat);
      {in2, in1, in0} = 3'd2;
      controlIn = 1'b1;
      repeat (5) @(negedge hwclk);
      ack = 1'b1;
      @(negedge hwclk);
      ack = 1'b0;
      check("race_valid", 32'(valid), 1);
      check("race_value", 32'(value), 22);
      check("race_symbols", 32'(symbols), 32'(18'o000022));
      check("race_overrun", 32'(overrun), 0);
      repeat (4) @(negedge hwclk);
      controlIn = 1'b0;
      repeat (10) @(negedge hwclk);
      pulse_ack();
      check("race_ack_valid", 32'(valid), 0);

      // Timeout: three symbols then a long low gap
      send_sym(3'd5, 10, 10, lat);
      send_sym(3'd5, 10, 10, lat);
      send_sym(3'd5, 10, 500, lat);
      check("tmo_mid_busy", 32'(busy), 1);
      check("tmo_mid_err", 32'(timeout_err), 0);
      repeat (510) @(negedge hwclk);
      check("tmo_err", 32'(timeout_err), 1);
      check("tmo_valid", 32'(valid), 0);
      check("tmo_busy", 32'(busy), 0);
      send_frame(18'o777777, 10, 10, 1'b0, lat);
      check("tmo_next_value", 32'(value), 777777);
      check("tmo_next_valid", 32'(valid), 1);
      check("tmo_err_sticky", 32'(timeout_err), 1);

      // Async reset mid-frame
      for (int i = 0; i < 4; i++) send_sym(3'(i + 1), 10, 10, lat);
      check("rst_mid_busy", 32'(busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      @(negedge hwclk);
      rst_n = 1'b1;
      @(negedge hwclk);

      // Enable drop mid-frame discards the partial frame
      for (int i = 0; i < 4; i++) send_sym(3'(7 - i), 10, 10, lat);
      check("en_mid_busy", 32'(busy), 1);
      enabled = 1'b0;
      @(negedge hwclk);
      enabled = 1'b1;
      check("en_drop_busy", 32'(busy), 0);
      check("en_drop_valid", 32'(valid), 0);
      send_frame(18'o654321, 10, 10, 1'b0, lat);
      check("final_value", 32'(value), 654321);
      check("final_symbols", 32'(symbols), 32'(18'o654321));
      check("final_valid", 32'(valid), 1);
      check("final_busy", 32'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
